alarm_tone_driver: RTL and testbench

Consumer end of the one-hot buzzer alarm interface produced by the sensor-detect block. Takes the three alarm level lines and drives a single piezo pin with a channel-specific square-wave tone. Enforces a minimum burst length and an inter-burst gap, and keeps a saturating alarm event count for status readout on the top-level pins.

---
 rtl/alarm_tone_driver.sv | 153 +++++++++++++++
 tb/tb_alarm_tone_driver.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/alarm_tone_driver.sv
// Piezo tone driver for the one-hot buzzer alarm lines: per-channel square wave,
// minimum burst length, forced silent gap, and a saturating burst counter.
module alarm_tone_driver #(
  parameter int DIV1      = 4,
  parameter int DIV2      = 6,
  parameter int DIV3      = 8,
  parameter int MIN_BURST = 16,
  parameter int GAP_LEN   = 4,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic [2:0]       alarm_in,
  input  logic             clr_count,
  output logic             piezo,
  output logic             tone_active,
  output logic [1:0]       alarm_id,
  output logic [CNT_W-1:0] event_count
);

  localparam int MAXDIV = (DIV1 > DIV2) ? ((DIV1 > DIV3) ? DIV1 : DIV3)
                                        : ((DIV2 > DIV3) ? DIV2 : DIV3);
  localparam int HW = (MAXDIV > 1) ? $clog2(MAXDIV) : 1;
  localparam int BW = $clog2(MIN_BURST + 1);
  localparam int GW = (GAP_LEN > 1) ? $clog2(GAP_LEN) : 1;

  localparam logic [HW-1:0]    RLD1      = HW'(DIV1 - 1);
  localparam logic [HW-1:0]    RLD2      = HW'(DIV2 - 1);
  localparam logic [HW-1:0]    RLD3      = HW'(DIV3 - 1);
  localparam logic [BW-1:0]    BURST_MAX = BW'(MIN_BURST);
  localparam logic [GW-1:0]    GAP_RLD   = GW'(GAP_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  typedef enum logic [1:0] {IDLE, TONE, GAP} state_t;

  state_t           state_q, state_d;
  logic             piezo_q, piezo_d;
  logic             tone_q, tone_d;
  logic [1:0]       id_q, id_d;
  logic [HW-1:0]    half_q, half_d;
  logic [BW-1:0]    burst_q, burst_d;
  logic [GW-1:0]    gap_q, gap_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [1:0] sel_id;
  logic       ch_live;

  function automatic logic [HW-1:0] reload(input logic [1:0] id);
    case (id)
      2'd1:    reload = RLD1;
      2'd2:    reload = RLD2;
      default: reload = RLD3;
    endcase
  endfunction

  always_comb begin
    // Lowest set bit wins when the detector reports more than one channel.
    if (alarm_in[0])      sel_id = 2'd1;
    else if (alarm_in[1]) sel_id = 2'd2;
    else if (alarm_in[2]) sel_id = 2'd3;
    else                  sel_id = 2'd0;

    case (id_q)
      2'd1:    ch_live = alarm_in[0];
      2'd2:    ch_live = alarm_in[1];
      2'd3:    ch_live = alarm_in[2];
      default: ch_live = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    piezo_d = piezo_q;
    tone_d  = tone_q;
    id_d    = id_q;
    half_d  = half_q;
    burst_d = burst_q;
    gap_d   = gap_q;
    cnt_d   = cnt_q;

    case (state_q)
      IDLE: begin
        piezo_d = 1'b0;
        tone_d  = 1'b0;
        id_d    = 2'd0;
        if (alarm_in != 3'b000) begin
          state_d = TONE;
          piezo_d = 1'b1;
          tone_d  = 1'b1;
          id_d    = sel_id;
          half_d  = reload(sel_id);
          burst_d = BW'(1);
          if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
        end
      end
      TONE: begin
        if (!ch_live && (burst_q >= BURST_MAX)) begin
          state_d = GAP;
          piezo_d = 1'b0;
          tone_d  = 1'b0;
          id_d    = 2'd0;
          gap_d   = GAP_RLD;
        end else begin
          if (half_q == '0) begin
            piezo_d = ~piezo_q;
            half_d  = reload(id_q);
          end else begin
            half_d  = half_q - HW'(1);
          end
          if (burst_q != BURST_MAX) burst_d = burst_q + BW'(1);
        end
      end
      GAP: begin
        piezo_d = 1'b0;
        if (gap_q == '0) state_d = IDLE;
        else             gap_d   = gap_q - GW'(1);
      end
      default: state_d = IDLE;
    endcase

    // Clearing beats a simultaneous burst-start increment.
    if (clr_count) cnt_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      piezo_q <= 1'b0;
      tone_q  <= 1'b0;
      id_q    <= 2'd0;
      half_q  <= '0;
      burst_q <= '0;
      gap_q   <= '0;
      cnt_q   <= '0;
    end else if (ena) begin
      state_q <= state_d;
      piezo_q <= piezo_d;
      tone_q  <= tone_d;
      id_q    <= id_d;
      half_q  <= half_d;
      burst_q <= burst_d;
      gap_q   <= gap_d;
      cnt_q   <= cnt_d;
    end
  end

  assign piezo       = piezo_q;
  assign tone_active = tone_q;
  assign alarm_id    = id_q;
  assign event_count = cnt_q;

endmodule

// File: tb/tb_alarm_tone_driver.sv
// Directed bench for alarm_tone_driver: tone shape, burst/gap timing, freeze,
// async reset and counter saturation/clear.
module tb_alarm_tone_driver;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ena = 1'b1;
  logic [2:0] alarm_in = 3'b000;
  logic       clr_count = 1'b0;
  logic       piezo;
  logic       tone_active;
  logic [1:0] alarm_id;
  logic [7:0] event_count;

  int checks = 0;
  int failures = 0;

  alarm_tone_driver dut (
    .clk         (clk),
    .rst         (rst),
    .ena         (ena),
    .alarm_in    (alarm_in),
    .clr_count   (clr_count),
    .piezo       (piezo),
    .tone_active (tone_active),
    .alarm_id    (alarm_id),
    .event_count (event_count)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "bench timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_tone(input string tag, input logic [1:0] id, input logic pz);
    check({tag, "_tone"},  32'(tone_active), 32'd1);
    check({tag, "_id"},    32'(alarm_id),    32'(id));
    check({tag, "_piezo"}, 32'(piezo),       32'(pz));
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_tone"},  32'(tone_active), 32'd0);
    check({tag, "_id"},    32'(alarm_id),    32'd0);
    check({tag, "_piezo"}, 32'(piezo),       32'd0);
  endtask

  task automatic do_reset();
    alarm_in  = 3'b000;
    clr_count = 1'b0;
    ena       = 1'b1;
    rst       = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    // Test 1: reset state, channel 1 held for 31 cycles
    @(negedge clk);
    do_reset();
    check_quiet("rst");
    check("rst_cnt", 32'(event_count), 32'd0);
    alarm_in = 3'b001;
    for (int j = 0; j < 31; j++) begin
      tick();
      check_tone("t1", 2'd1, ((j / 4) % 2) == 0);
    end
    alarm_in = 3'b000;
    for (int g = 0; g < 4; g++) begin
      tick();
      check_quiet("t1_gap");
    end
    tick();
    check_quiet("t1_idle");
    check("t1_cnt", 32'(event_count), 32'd1);

    // Test 2: 3-cycle pulse on channel 2 stretched to MIN_BURST
    do_reset();
    alarm_in = 3'b010;
    for (int j = 0; j < 16; j++) begin
      tick();
      if (j == 2) alarm_in = 3'b000;
      check_tone("t2", 2'd2, ((j / 6) % 2) == 0);
    end
    for (int g = 0; g < 4; g++) begin
      tick();
      check_quiet("t2_gap");
    end
    tick();
    check_quiet("t2_idle");
    check("t2_cnt", 32'(event_count), 32'd1);

    // Test 3: multi-hot 101 selects channel 1; later bit changes ignored
    do_reset();
    for (int j = 0; j < 16; j++) begin
      alarm_in = (j < 10) ? 3'b101 : 3'b100;
      tick();
      check_tone("t3", 2'd1, ((j / 4) % 2) == 0);
    end
    for (int g = 0; g < 4; g++) begin
      tick();
      check_quiet("t3_gap");
    end
    alarm_in = 3'b000;
    tick();
    check_quiet("t3_idle");
    check("t3_cnt", 32'(event_count), 32'd1);

    // Test 4: channel 3, input re-asserted during gap starts a second burst
    do_reset();
    alarm_in = 3'b100;
    for (int j = 0; j < 20; j++) begin
      tick();
      check_tone("t4", 2'd3, ((j / 8) % 2) == 0);
    end
    alarm_in = 3'b000;
    tick();
    check_quiet("t4_gap0");
    alarm_in = 3'b100;
    for (int g = 1; g < 4; g++) begin
      tick();
      check_quiet("t4_gap");
    end
    tick();
    check_quiet("t4_idle");
    tick();
    check_tone("t4_b2", 2'd3, 1'b1);
    check("t4_cnt", 32'(event_count), 32'd2);
    alarm_in = 3'b000;

    // Test 5: freeze mid-tone (clr_count ignored), then async reset
    do_reset();
    alarm_in = 3'b001;
    for (int j = 0; j < 3; j++) begin
      tick();
      check_tone("t5_pre", 2'd1, ((j / 4) % 2) == 0);
    end
    ena = 1'b0;
    clr_count = 1'b1;
    for (int f = 0; f < 5; f++) begin
      tick();
      check_tone("t5_frz", 2'd1, 1'b1);
      check("t5_frz_cnt", 32'(event_count), 32'd1);
    end
    ena = 1'b1;
    clr_count = 1'b0;
    for (int j = 3; j < 10; j++) begin
      tick();
      check_tone("t5_post", 2'd1, ((j / 4) % 2) == 0);
    end
    rst = 1'b1;
    #1;
    check_quiet("t5_arst");
    check("t5_arst_cnt", 32'(event_count), 32'd0);
    alarm_in = 3'b000;
    tick();
    rst = 1'b0;

    // Test 6: saturation, clear, clear coinciding with burst start
    do_reset();
    for (int b = 1; b <= 260; b++) begin
      alarm_in = 3'b001;
      tick();
      alarm_in = 3'b000;
      repeat (20) tick();
      if (b == 255) check("t6_cnt255", 32'(event_count), 32'd255);
    end
    check("t6_sat", 32'(event_count), 32'd255);
    clr_count = 1'b1;
    tick();
    clr_count = 1'b0;
    check("t6_clr", 32'(event_count), 32'd0);
    alarm_in = 3'b001;
    tick();
    alarm_in = 3'b000;
    repeat (20) tick();
    check("t6_one", 32'(event_count), 32'd1);
    alarm_in = 3'b001;
    clr_count = 1'b1;
    tick();
    clr_count = 1'b0;
    alarm_in = 3'b000;
    check("t6_clr_entry", 32'(event_count), 32'd0);
    check_tone("t6_entry", 2'd1, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
